mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Sits directly downstream of the core: merges its instruction refill port (o_iaddr/o_iread_en/
//  i_inst/i_iread_vd) and data port (o_memaddr/o_read_en/o_write_en/o_write_data/i_read_data/
//  i_read_vd) onto one single-port req/ack memory bus. Data beats instruction; o_exstall holds
//  the core until a data access completes. Optional watchdog aborts hung transfers.
// PARAMETERS
//  ADDR_W   32  address width
//  DATA_W   32  data width
//  TIMEOUT  0   cycles to wait for i_mem_ack before abort; 0 = watchdog disabled
// PORTS
//  clk           in   1       clock
//  rst           in   1       synchronous, active-high reset
//  i_iaddr       in   ADDR_W  core fetch address (core o_iaddr)
//  i_iread_en    in   1       core i-cache miss (core o_iread_en)
//  o_inst        out  DATA_W  refill word (to core i_inst)
//  o_iread_vd    out  1       refill valid, 1-cycle pulse (to core i_iread_vd)
//  i_memaddr     in   ADDR_W  data address
//  i_read_en     in   1       data load request
//  i_write_en    in   1       data store request
//  i_write_data  in   DATA_W  store data
//  o_read_data   out  DATA_W  load data
//  o_read_vd     out  1       load data valid, 1-cycle pulse
//  o_exstall     out  1       stall to core (core i_exstall)
//  o_mem_req     out  1       bus request, held until ack
//  o_mem_we      out  1       bus write
//  o_mem_addr    out  ADDR_W  bus address
//  o_mem_wdata   out  DATA_W  bus write data
//  i_mem_ack     in   1       bus completion; i_mem_rdata valid same cycle
//  i_mem_rdata   in   DATA_W  bus read data
//  o_bus_err     out  1       1-cycle pulse on watchdog abort
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0 except o_exstall, which follows its equation (0 when no data req).
//  - dreq = i_read_en | i_write_en. o_exstall = dreq & (state != DDONE) (combinational).
//  - States IDLE, IFETCH, DACC, DDONE. Bus outputs registered, stable while o_mem_req=1.
//  - IDLE: dreq -> latch i_memaddr/i_write_data, o_mem_we=i_write_en, o_mem_req=1, -> DACC.
//    else i_iread_en -> latch i_iaddr, o_mem_we=0, o_mem_req=1, -> IFETCH. Data wins ties.
//  - IFETCH: on i_mem_ack: o_mem_req<=0; o_inst<=i_mem_rdata; o_iread_vd<=1 only if
//    i_iaddr == latched addr (fetch not redirected), else word dropped; -> IDLE. Pending dreq
//    waits (stalled) and is served next from IDLE; fetch is never preempted.
//  - DACC: on i_mem_ack: o_mem_req<=0; if read, o_read_data<=i_mem_rdata, o_read_vd<=1; -> DDONE.
//  - DDONE: one cycle, o_exstall=0 so core advances exactly once; no new request accepted; -> IDLE.
//    Latency: data op with ack on bus cycle N -> o_read_vd and exstall low in cycle N+1.
//  - i_read_en & i_write_en together: treated as write (o_mem_we=1), no o_read_vd.
//  - Watchdog (TIMEOUT>0): counter clears on entry to IFETCH/DACC, increments each cycle without
//    ack; at TIMEOUT: drop o_mem_req, pulse o_bus_err; IFETCH -> IDLE (no vd); DACC -> DDONE with
//    o_read_data=0, o_read_vd=1 for reads. Ack in same cycle as timeout: ack wins.
//  - rst mid-transfer: o_mem_req drops next edge, state IDLE, late ack ignored in IDLE.
//  - o_iread_vd/o_read_vd/o_bus_err are single-cycle pulses, never both vd in one cycle.
// TESTING
//  1. Ifetch: iread_en=1, iaddr=0x100, ack after 3 cycles, rdata=0x00000013 -> one req, we=0,
//     addr=0x100, o_inst=0x13, o_iread_vd pulse 1 cycle after ack.
//  2. Load: read_en=1, addr=0x2000, ack rdata=0xDEADBEEF -> exstall high until DDONE,
//     o_read_data=0xDEADBEEF, o_read_vd 1 cycle, exstall low exactly 1 cycle in DDONE.
//  3. Store+fetch same cycle: write_en=1 addr=0x40 wdata=0x55, iread_en=1 iaddr=0x8 -> store
//     issued first (we=1, wdata=0x55), fetch 0x8 issued 2 cycles after store ack.
//  4. Redirect: fetch 0x100 in flight, iaddr changes to 0x200 before ack -> no o_iread_vd,
//     next request addr=0x200.
//  5. Watchdog TIMEOUT=8, no ack on load -> o_bus_err pulse after 8 cycles, o_read_vd with
//     data 0, req deasserted; rst asserted mid-fetch -> req 0 next cycle, late ack no pulse.

Source files
------------

// File: rtl/mem_arbiter.sv
// Merges the core's instruction-refill and data ports onto one single-port req/ack bus.
// Data accesses win over fetches; an optional watchdog aborts transfers that never get an ack.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_iaddr,
  input  logic              i_iread_en,
  output logic [DATA_W-1:0] o_inst,
  output logic              o_iread_vd,
  input  logic [ADDR_W-1:0] i_memaddr,
  input  logic              i_read_en,
  input  logic              i_write_en,
  input  logic [DATA_W-1:0] i_write_data,
  output logic [DATA_W-1:0] o_read_data,
  output logic              o_read_vd,
  output logic              o_exstall,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_bus_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, IFETCH, DACC, DDONE} state_t;

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   inst_q, inst_d;
  logic                iread_vd_q, iread_vd_d;
  logic [DATA_W-1:0]   read_data_q, read_data_d;
  logic                read_vd_q, read_vd_d;
  logic                bus_err_q, bus_err_d;
  logic                is_read_q, is_read_d;
  logic [CNT_W-1:0]    wd_cnt_q, wd_cnt_d;
  logic                dreq;
  logic                timeout_hit;

  assign dreq        = i_read_en | i_write_en;
  assign timeout_hit = (TIMEOUT != 0) && (wd_cnt_q == CNT_MAX);
  assign o_exstall   = dreq & (state_q != DDONE);

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    inst_d      = inst_q;
    iread_vd_d  = 1'b0;
    read_data_d = read_data_q;
    read_vd_d   = 1'b0;
    bus_err_d   = 1'b0;
    is_read_d   = is_read_q;
    wd_cnt_d    = wd_cnt_q;
    case (state_q)
      IDLE: begin
        if (dreq) begin
          mem_addr_d  = i_memaddr;
          mem_wdata_d = i_write_data;
          mem_we_d    = i_write_en;
          is_read_d   = i_read_en & ~i_write_en;
          mem_req_d   = 1'b1;
          wd_cnt_d    = '0;
          state_d     = DACC;
        end else if (i_iread_en) begin
          mem_addr_d = i_iaddr;
          mem_we_d   = 1'b0;
          mem_req_d  = 1'b1;
          wd_cnt_d   = '0;
          state_d    = IFETCH;
        end
      end
      IFETCH: begin
        if (i_mem_ack) begin
          mem_req_d  = 1'b0;
          inst_d     = i_mem_rdata;
          // A redirected fetch returns a stale word; drop it silently.
          iread_vd_d = (i_iaddr == mem_addr_q);
          state_d    = IDLE;
        end else if (timeout_hit) begin
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
      end
      DACC: begin
        if (i_mem_ack) begin
          mem_req_d = 1'b0;
          if (is_read_q) begin
            read_data_d = i_mem_rdata;
            read_vd_d   = 1'b1;
          end
          state_d = DDONE;
        end else if (timeout_hit) begin
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (is_read_q) begin
            read_data_d = '0;
            read_vd_d   = 1'b1;
          end
          state_d = DDONE;
        end else begin
          wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
      end
      DDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      inst_q      <= '0;
      iread_vd_q  <= 1'b0;
      read_data_q <= '0;
      read_vd_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      is_read_q   <= 1'b0;
      wd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      inst_q      <= inst_d;
      iread_vd_q  <= iread_vd_d;
      read_data_q <= read_data_d;
      read_vd_q   <= read_vd_d;
      bus_err_q   <= bus_err_d;
      is_read_q   <= is_read_d;
      wd_cnt_q    <= wd_cnt_d;
    end
  end

  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_inst      = inst_q;
  assign o_iread_vd  = iread_vd_q;
  assign o_read_data = read_data_q;
  assign o_read_vd   = read_vd_q;
  assign o_bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter (TIMEOUT=8): directed scenarios plus a randomized core/memory,
// every cycle compared against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_iaddr = '0;
  logic        i_iread_en = 1'b0;
  logic [31:0] o_inst;
  logic        o_iread_vd;
  logic [31:0] i_memaddr = '0;
  logic        i_read_en = 1'b0;
  logic        i_write_en = 1'b0;
  logic [31:0] i_write_data = '0;
  logic [31:0] o_read_data;
  logic        o_read_vd;
  logic        o_exstall;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        o_bus_err;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_iaddr(i_iaddr), .i_iread_en(i_iread_en), .o_inst(o_inst), .o_iread_vd(o_iread_vd),
    .i_memaddr(i_memaddr), .i_read_en(i_read_en), .i_write_en(i_write_en),
    .i_write_data(i_write_data), .o_read_data(o_read_data), .o_read_vd(o_read_vd),
    .o_exstall(o_exstall), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack),
    .i_mem_rdata(i_mem_rdata), .o_bus_err(o_bus_err)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one outstanding bus transaction plus the one-cycle data hand-back.
  bit          m_busy = 0, m_fetch = 0, m_we = 0, m_rd = 0, m_ddone = 0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  int unsigned m_wait = 0;
  logic [31:0] e_inst = '0, e_rdata = '0;
  bit          e_ivd = 0, e_rvd = 0, e_err = 0;

  task automatic step(input bit r, input bit ie, input logic [31:0] ia, input bit re,
                      input bit wr, input logic [31:0] ma, input logic [31:0] wd,
                      input bit ak, input logic [31:0] rd);
    @(negedge clk);
    rst = r; i_iread_en = ie; i_iaddr = ia; i_read_en = re; i_write_en = wr;
    i_memaddr = ma; i_write_data = wd; i_mem_ack = ak; i_mem_rdata = rd;
    #1;
    check_eq("req", 32'(o_mem_req), 32'(m_busy));
    if (m_busy) begin
      check_eq("addr", o_mem_addr, m_addr);
      check_eq("we", 32'(o_mem_we), 32'(m_we));
      if (m_we) check_eq("wdata", o_mem_wdata, m_wdata);
    end
    check_eq("inst", o_inst, e_inst);
    check_eq("ivd", 32'(o_iread_vd), 32'(e_ivd));
    check_eq("rdata", o_read_data, e_rdata);
    check_eq("rvd", 32'(o_read_vd), 32'(e_rvd));
    check_eq("buserr", 32'(o_bus_err), 32'(e_err));
    check_eq("exstall", 32'(o_exstall), 32'((re | wr) & !m_ddone));
    e_ivd = 0; e_rvd = 0; e_err = 0;
    if (r) begin
      m_busy = 0; m_ddone = 0; e_inst = '0; e_rdata = '0;
    end else if (m_ddone) begin
      m_ddone = 0;
    end else if (m_busy) begin
      if (ak) begin
        m_busy = 0;
        if (m_fetch) begin
          e_inst = rd; e_ivd = (ia == m_addr);
        end else begin
          if (m_rd) begin e_rdata = rd; e_rvd = 1; end
          m_ddone = 1;
        end
      end else if (m_wait + 1 == TO) begin
        m_busy = 0; e_err = 1;
        if (!m_fetch) begin
          m_ddone = 1;
          if (m_rd) begin e_rdata = '0; e_rvd = 1; end
        end
      end else begin
        m_wait++;
      end
    end else if (re | wr) begin
      m_busy = 1; m_fetch = 0; m_we = wr; m_rd = re & !wr;
      m_addr = ma; m_wdata = wd; m_wait = 0;
    end else if (ie) begin
      m_busy = 1; m_fetch = 1; m_we = 0; m_addr = ia; m_wait = 0;
    end
  endtask

  task automatic after_edge();
    @(posedge clk); #1;
  endtask

  bit          pend, re_c, wr_c, ie_c, was_dd, was_busy, r_c, ak_c;
  logic [31:0] ma_c, wd_c, ia_c;
  int unsigned dly, kind;

  initial begin
    // Reset
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    after_edge();
    check_eq("rst_req", 32'(o_mem_req), 32'd0);
    check_eq("rst_exstall", 32'(o_exstall), 32'd0);

    // Instruction fetch, ack after 3 wait cycles
    step(0, 1, 32'h100, 0, 0, 0, 0, 0, 0);
    after_edge();
    check_eq("t1_req", 32'(o_mem_req), 32'd1);
    check_eq("t1_addr", o_mem_addr, 32'h100);
    check_eq("t1_we", 32'(o_mem_we), 32'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 32'h100, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h100, 0, 0, 0, 0, 1, 32'h13);
    after_edge();
    check_eq("t1_ivd", 32'(o_iread_vd), 32'd1);
    check_eq("t1_inst", o_inst, 32'h13);
    check_eq("t1_req_low", 32'(o_mem_req), 32'd0);
    step(0, 0, 32'h100, 0, 0, 0, 0, 0, 0);

    // Load
    step(0, 0, 0, 1, 0, 32'h2000, 0, 0, 0);
    step(0, 0, 0, 1, 0, 32'h2000, 0, 0, 0);
    step(0, 0, 0, 1, 0, 32'h2000, 0, 1, 32'hDEADBEEF);
    after_edge();
    check_eq("t2_rvd", 32'(o_read_vd), 32'd1);
    check_eq("t2_rdata", o_read_data, 32'hDEADBEEF);
    check_eq("t2_exstall_ddone", 32'(o_exstall), 32'd0);
    step(0, 0, 0, 1, 0, 32'h2000, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Store and fetch together: store first, fetch follows after the hand-back cycle
    step(0, 1, 32'h8, 0, 1, 32'h40, 32'h55, 0, 0);
    after_edge();
    check_eq("t3_we", 32'(o_mem_we), 32'd1);
    check_eq("t3_wdata", o_mem_wdata, 32'h55);
    check_eq("t3_addr", o_mem_addr, 32'h40);
    step(0, 1, 32'h8, 0, 1, 32'h40, 32'h55, 1, 0);
    step(0, 1, 32'h8, 0, 1, 32'h40, 32'h55, 0, 0);
    step(0, 1, 32'h8, 0, 0, 0, 0, 0, 0);
    after_edge();
    check_eq("t3_fetch_addr", o_mem_addr, 32'h8);
    check_eq("t3_fetch_we", 32'(o_mem_we), 32'd0);
    step(0, 1, 32'h8, 0, 0, 0, 0, 1, 32'h77);
    step(0, 0, 32'h8, 0, 0, 0, 0, 0, 0);

    // Redirected fetch
    step(0, 1, 32'h100, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h200, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h200, 0, 0, 0, 0, 1, 32'h99);
    after_edge();
    check_eq("t4_no_ivd", 32'(o_iread_vd), 32'd0);
    step(0, 1, 32'h200, 0, 0, 0, 0, 0, 0);
    after_edge();
    check_eq("t4_next_addr", o_mem_addr, 32'h200);
    step(0, 1, 32'h200, 0, 0, 0, 0, 1, 32'h5);
    step(0, 0, 32'h200, 0, 0, 0, 0, 0, 0);

    // Watchdog abort of a load
    step(0, 0, 0, 1, 0, 32'h3000, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0, 32'h3000, 0, 0, 0);
    after_edge();
    check_eq("t5_buserr", 32'(o_bus_err), 32'd1);
    check_eq("t5_rvd", 32'(o_read_vd), 32'd1);
    check_eq("t5_rdata", o_read_data, 32'd0);
    check_eq("t5_req", 32'(o_mem_req), 32'd0);
    step(0, 0, 0, 1, 0, 32'h3000, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a fetch, late ack ignored
    step(0, 1, 32'h500, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h500, 0, 0, 0, 0, 0, 0);
    step(1, 1, 32'h500, 0, 0, 0, 0, 0, 0);
    after_edge();
    check_eq("t5_rst_req", 32'(o_mem_req), 32'd0);
    step(0, 0, 32'h500, 0, 0, 0, 0, 1, 32'h1);
    after_edge();
    check_eq("t5_late_ack", 32'(o_iread_vd), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized core and memory
    pend = 0; re_c = 0; wr_c = 0; ie_c = 0; ia_c = '0; ma_c = '0; wd_c = '0; dly = 0;
    for (int c = 0; c < 4000; c++) begin
      r_c = ($urandom_range(199) == 0);
      if (!pend && $urandom_range(3) == 0) begin
        pend = 1;
        kind = $urandom_range(2);
        re_c = (kind != 1);
        wr_c = (kind != 0);
        ma_c = $urandom;
        wd_c = $urandom;
      end
      if ($urandom_range(5) == 0) ie_c = ~ie_c;
      if ($urandom_range(7) == 0) ia_c = $urandom & 32'h0000_00FC;
      if (m_busy) ak_c = (m_wait >= dly);
      else        ak_c = ($urandom_range(5) == 0);
      was_dd   = m_ddone;
      was_busy = m_busy;
      step(r_c, ie_c, ia_c, pend & re_c, pend & wr_c, ma_c, wd_c, ak_c, $urandom);
      if (was_dd && pend) pend = 0;
      if (!was_busy && m_busy) dly = $urandom_range(10);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
